od_bus_responder: RTL

Responder end of the 8-bit open-drain handshake bus carried on the pulled-up `io_bus0` / pulled-down `io_bus1` pair that submodules share through `tran` links at the top level. An initiator on the same pair issues a command byte and then a data byte, each with a 4-phase REQ/ACK handshake. This block decodes the command, serves reads from and accepts writes to a 16x8 register file, and reports writes to local logic. It is the counterpart of the bus initiator and drives the bus only by pulling lines away from their resistive default, never against it.

---
 rtl/od_bus_responder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/od_bus_responder.sv
// od_bus_responder
// Responder end of the 8-bit open-drain REQ/ACK handshake bus.
// A command byte selects read/write and a register-file address. A data byte
// then either writes the register file or is served from it. Lines are only
// ever pulled away from their resistive default: bus0 is driven to 0 or
// released, and bus1 is driven to 1 or released.
module od_bus_responder #(
    parameter int          TIMEOUT   = 255,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [7:0]  io_bus0,
    inout  wire  [7:0]  io_bus1,
    output logic        wr_pulse,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        err_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        CMD_ACK,
        CMD_REL,
        DATA_WAIT,
        RD_DRV,
        DATA_ACK,
        DATA_REL
    } state_t;

    // DATA_REL is kept in the encoding but never entered: DATA_ACK returns
    // straight to IDLE so that a back-to-back command is not missed.

    // Synchronised bus inputs
    logic        req_meta_reg;
    logic        req_s_reg;
    logic        req_s_d_reg;
    logic [7:0]  bus0_meta_reg;
    logic [7:0]  bus0_s_reg;
    logic        req_rise;
    logic        req_fall;

    // FSM state and pin drives
    state_t      state_reg;
    logic [7:0]  cmd_reg;
    logic        ack_reg;
    logic        nak_reg;
    logic [7:0]  drv0_reg;        // 1 = pull the matching bus0 bit low
    logic [15:0] cnt_reg;

    // Register file
    logic [7:0]  regs [16];
    logic [7:0]  rd_data;
    logic        wr_commit;

    // Bits of bus1 this block never looks at
    logic        unused_bus1;

    assign unused_bus1 = ^io_bus1[7:1];

    // Two-flop synchronisers for REQ and bus0, plus REQ edge history
    always_ff @(posedge clock) begin
        if (!reset) begin
            req_meta_reg  <= 1'b0;
            req_s_reg     <= 1'b0;
            req_s_d_reg   <= 1'b0;
            bus0_meta_reg <= 8'hFF;
            bus0_s_reg    <= 8'hFF;
        end else begin
            req_meta_reg  <= io_bus1[0];
            req_s_reg     <= req_meta_reg;
            req_s_d_reg   <= req_s_reg;
            bus0_meta_reg <= io_bus0;
            bus0_s_reg    <= bus0_meta_reg;
        end
    end

    assign req_rise = req_s_reg & ~req_s_d_reg;
    assign req_fall = ~req_s_reg & req_s_d_reg;

    // A data-phase REQ rise on a write command commits the synchronised byte
    assign wr_commit = (state_reg == DATA_WAIT) && req_rise && !cmd_reg[7];
    assign rd_data   = regs[cmd_reg[3:0]];

    // Register file: one entry per generate slot, written only from the bus
    for (genvar gi = 0; gi < 16; gi++) begin : g_regs
        // Reset to RESET_VAL, otherwise take the bus byte when addressed
        always_ff @(posedge clock) begin
            if (!reset) begin
                regs[gi] <= RESET_VAL;
            end else if (wr_commit && (cmd_reg[3:0] == 4'(gi))) begin
                regs[gi] <= bus0_s_reg;
            end
        end
    end

    // Handshake FSM with registered pin drives and strobes
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            cmd_reg   <= 8'h00;
            ack_reg   <= 1'b0;
            nak_reg   <= 1'b0;
            drv0_reg  <= 8'h00;
            cnt_reg   <= 16'h0000;
            wr_pulse  <= 1'b0;
            wr_addr   <= 4'h0;
            wr_data   <= 8'h00;
            err_pulse <= 1'b0;
        end else begin
            wr_pulse  <= 1'b0;
            err_pulse <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_rise) begin
                        cmd_reg <= bus0_s_reg;
                        ack_reg <= 1'b1;
                        if (bus0_s_reg[6:4] != 3'b000) begin
                            // Malformed command: refuse it, but still complete
                            // the handshake so the initiator can recover.
                            nak_reg   <= 1'b1;
                            err_pulse <= 1'b1;
                            state_reg <= CMD_REL;
                        end else begin
                            state_reg <= CMD_ACK;
                        end
                    end
                end

                CMD_ACK: begin
                    if (req_fall) begin
                        ack_reg   <= 1'b0;
                        cnt_reg   <= 16'(TIMEOUT);
                        state_reg <= DATA_WAIT;
                    end
                end

                CMD_REL: begin
                    if (req_fall) begin
                        ack_reg   <= 1'b0;
                        nak_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                DATA_WAIT: begin
                    if (req_rise) begin
                        if (cmd_reg[7]) begin
                            // Present read data one cycle ahead of ACK
                            drv0_reg  <= ~rd_data;
                            state_reg <= RD_DRV;
                        end else begin
                            wr_pulse  <= 1'b1;
                            wr_addr   <= cmd_reg[3:0];
                            wr_data   <= bus0_s_reg;
                            ack_reg   <= 1'b1;
                            state_reg <= DATA_ACK;
                        end
                    end else if (cnt_reg == 16'h0000) begin
                        // Initiator never sent its data byte; abandon it
                        err_pulse <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 16'h0001;
                    end
                end

                RD_DRV: begin
                    ack_reg   <= 1'b1;
                    state_reg <= DATA_ACK;
                end

                DATA_ACK: begin
                    if (req_fall) begin
                        ack_reg   <= 1'b0;
                        drv0_reg  <= 8'h00;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    ack_reg   <= 1'b0;
                    nak_reg   <= 1'b0;
                    drv0_reg  <= 8'h00;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Open-drain data drivers: pull low or release
    for (genvar gi = 0; gi < 8; gi++) begin : g_bus0
        assign io_bus0[gi] = drv0_reg[gi] ? 1'b0 : 1'bz;
    end

    // Control lines: ACK and NAK pulled high when asserted, all others released
    assign io_bus1[0] = 1'bz;
    assign io_bus1[1] = ack_reg ? 1'b1 : 1'bz;
    assign io_bus1[2] = nak_reg ? 1'b1 : 1'bz;
    for (genvar gi = 3; gi < 8; gi++) begin : g_bus1_free
        assign io_bus1[gi] = 1'bz;
    end

endmodule
